snake_move_ctrl: RTL and testbench

SNAKE_MOVE_CTRL -- requirements
Module: snake_move_ctrl

---
 rtl/snake_move_ctrl_if.sv | 28 ++
 rtl/snake_move_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_snake_move_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snake_move_ctrl_if.sv
// Control/status bundle between the game logic and the snake movement controller.
interface snake_move_ctrl_if;
  logic       init;
  logic       pause;
  logic       key_valid;
  logic [7:0] key_code;
  logic [4:0] food_x;
  logic [4:0] food_y;
  logic [4:0] qry_x;
  logic [4:0] qry_y;
  logic       qry_hit;
  logic [4:0] head_x;
  logic [4:0] head_y;
  logic [4:0] length;
  logic       step;
  logic       ate;
  logic       died;

  modport master (
    output init, pause, key_valid, key_code, food_x, food_y, qry_x, qry_y,
    input  qry_hit, head_x, head_y, length, step, ate, died
  );

  modport slave (
    input  init, pause, key_valid, key_code, food_x, food_y, qry_x, qry_y,
    output qry_hit, head_x, head_y, length, step, ate, died
  );
endinterface

// File: rtl/snake_move_ctrl.sv
// Snake movement controller on a 32x24 grid: step timing, direction filtering,
// next-head evaluation (wall/self/food) and the body segment shift register.
module snake_move_ctrl #(
  parameter int TICK_DIV = 10_000_000,
  parameter int MAX_LEN  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  snake_move_ctrl_if.slave bus
);

  localparam int              CW        = $clog2(TICK_DIV);
  localparam logic [CW-1:0]   TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [4:0]      X_MAX     = 5'd31;
  localparam logic [4:0]      Y_MAX     = 5'd23;
  localparam logic [4:0]      LEN_RST   = 5'd3;
  localparam logic [4:0]      LEN_MAX   = 5'(MAX_LEN);
  localparam logic [7:0]      KEY_W     = 8'h1D;
  localparam logic [7:0]      KEY_A     = 8'h1C;
  localparam logic [7:0]      KEY_S     = 8'h1B;
  localparam logic [7:0]      KEY_D     = 8'h23;

  // Opposite directions differ only in bit 1, which makes the reverse test an XOR.
  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_CALC   = 3'd2,
    S_COMMIT = 3'd3,
    S_DEAD   = 3'd4
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] tick_reg;
  dir_t          committed_reg, pending_reg;
  logic [4:0]    length_reg;
  logic          step_reg, ate_reg, died_reg;
  logic [4:0]    nx_reg, ny_reg;
  logic          wall_reg, self_reg, eat_reg;

  logic          key_is_dir;
  dir_t          key_dir;
  dir_t          ref_dir;
  logic          key_accept;
  logic          tick_wrap;
  logic [4:0]    nx_calc, ny_calc;
  logic          wall_calc, eat_calc, self_calc;
  logic          commit_move;
  logic [5:0]    len6;

  logic [4:0]         seg_x [MAX_LEN];
  logic [4:0]         seg_y [MAX_LEN];
  logic [MAX_LEN-1:0] self_vec;
  logic [MAX_LEN-1:0] qry_vec;

  always_comb begin
    key_is_dir = 1'b1;
    key_dir    = DIR_RIGHT;
    case (bus.key_code)
      KEY_W:   key_dir = DIR_UP;
      KEY_A:   key_dir = DIR_LEFT;
      KEY_S:   key_dir = DIR_DOWN;
      KEY_D:   key_dir = DIR_RIGHT;
      default: key_is_dir = 1'b0;
    endcase
  end

  // During CALC the pending direction is the one being committed, so keys are
  // judged against it to avoid sneaking a reversal past the commit.
  assign ref_dir    = (state_reg == S_CALC) ? pending_reg : committed_reg;
  assign key_accept = bus.key_valid && key_is_dir && !bus.init &&
                      (state_reg != S_DEAD) &&
                      (key_dir != dir_t'(ref_dir ^ 2'b10));
  assign tick_wrap  = (tick_reg == TICK_LAST);
  assign len6       = {1'b0, length_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (key_accept) state_next = S_RUN;
      S_RUN:    if (!bus.pause && tick_wrap) state_next = S_CALC;
      S_CALC:   state_next = S_COMMIT;
      S_COMMIT: state_next = (wall_reg || self_reg) ? S_DEAD : S_RUN;
      S_DEAD:   state_next = S_DEAD;
      default:  state_next = S_IDLE;
    endcase
    if (bus.init) state_next = S_IDLE;
  end

  always_comb begin
    nx_calc   = seg_x[0];
    ny_calc   = seg_y[0];
    wall_calc = 1'b0;
    case (pending_reg)
      DIR_UP:    if (seg_y[0] == 5'd0)  wall_calc = 1'b1; else ny_calc = seg_y[0] - 5'd1;
      DIR_DOWN:  if (seg_y[0] >= Y_MAX) wall_calc = 1'b1; else ny_calc = seg_y[0] + 5'd1;
      DIR_LEFT:  if (seg_x[0] == 5'd0)  wall_calc = 1'b1; else nx_calc = seg_x[0] - 5'd1;
      DIR_RIGHT: if (seg_x[0] >= X_MAX) wall_calc = 1'b1; else nx_calc = seg_x[0] + 5'd1;
      default:   wall_calc = 1'b0;
    endcase
  end

  assign eat_calc    = !wall_calc && (nx_calc == bus.food_x) && (ny_calc == bus.food_y);
  assign self_calc   = |self_vec;
  assign commit_move = (state_reg == S_COMMIT) && !wall_reg && !self_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_reg      <= '0;
      committed_reg <= DIR_RIGHT;
      pending_reg   <= DIR_RIGHT;
      length_reg    <= LEN_RST;
      step_reg      <= 1'b0;
      ate_reg       <= 1'b0;
      died_reg      <= 1'b0;
      nx_reg        <= '0;
      ny_reg        <= '0;
      wall_reg      <= 1'b0;
      self_reg      <= 1'b0;
      eat_reg       <= 1'b0;
    end else if (bus.init) begin
      tick_reg      <= '0;
      committed_reg <= DIR_RIGHT;
      pending_reg   <= DIR_RIGHT;
      length_reg    <= LEN_RST;
      step_reg      <= 1'b0;
      ate_reg       <= 1'b0;
      died_reg      <= 1'b0;
      nx_reg        <= '0;
      ny_reg        <= '0;
      wall_reg      <= 1'b0;
      self_reg      <= 1'b0;
      eat_reg       <= 1'b0;
    end else begin
      step_reg <= 1'b0;
      ate_reg  <= 1'b0;
      died_reg <= 1'b0;
      if (key_accept) pending_reg <= key_dir;
      case (state_reg)
        S_RUN: begin
          if (!bus.pause) tick_reg <= tick_wrap ? '0 : tick_reg + CW'(1);
        end
        S_CALC: begin
          committed_reg <= pending_reg;
          nx_reg        <= nx_calc;
          ny_reg        <= ny_calc;
          wall_reg      <= wall_calc;
          self_reg      <= self_calc;
          eat_reg       <= eat_calc;
        end
        S_COMMIT: begin
          if (wall_reg || self_reg) begin
            died_reg <= 1'b1;
          end else begin
            step_reg <= 1'b1;
            ate_reg  <= eat_reg;
            if (eat_reg && (length_reg < LEN_MAX)) length_reg <= length_reg + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Segment i takes segment i-1 on every move; slots past the live length hold
  // stale copies, so eating only has to bump length to keep the old tail.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_LEN; gi++) begin : g_seg
      localparam logic [4:0] X_RST = (gi < 3) ? 5'(16 - gi) : 5'd0;
      localparam logic [4:0] Y_RST = (gi < 3) ? 5'd12 : 5'd0;
      localparam logic [5:0] IDX   = 6'(gi);

      logic [4:0] x_reg, y_reg;
      logic [4:0] x_src, y_src;

      if (gi == 0) begin : g_head
        assign x_src = nx_reg;
        assign y_src = ny_reg;
      end else begin : g_body
        assign x_src = seg_x[gi-1];
        assign y_src = seg_y[gi-1];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          x_reg <= X_RST;
          y_reg <= Y_RST;
        end else if (bus.init) begin
          x_reg <= X_RST;
          y_reg <= Y_RST;
        end else if (commit_move) begin
          x_reg <= x_src;
          y_reg <= y_src;
        end
      end

      assign seg_x[gi] = x_reg;
      assign seg_y[gi] = y_reg;

      // The tail vacates its cell on a plain move, but stays put when eating.
      assign self_vec[gi] = (x_reg == nx_calc) && (y_reg == ny_calc) &&
                            (eat_calc ? (IDX < len6) : ((IDX + 6'd1) < len6));
      assign qry_vec[gi]  = (x_reg == bus.qry_x) && (y_reg == bus.qry_y) && (IDX < len6);
    end
  endgenerate

  assign bus.qry_hit = |qry_vec;
  assign bus.head_x  = seg_x[0];
  assign bus.head_y  = seg_y[0];
  assign bus.length  = length_reg;
  assign bus.step    = step_reg;
  assign bus.ate     = ate_reg;
  assign bus.died    = died_reg;

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Self-checking bench for snake_move_ctrl: a queue-of-cells snake model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_snake_move_ctrl;

  localparam int TICK_DIV = 4;
  localparam int MAX_LEN  = 16;
  localparam logic [7:0] K_W = 8'h1D;
  localparam logic [7:0] K_A = 8'h1C;
  localparam logic [7:0] K_S = 8'h1B;
  localparam logic [7:0] K_D = 8'h23;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  snake_move_ctrl_if bus();

  snake_move_ctrl #(.TICK_DIV(TICK_DIV), .MAX_LEN(MAX_LEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_x [MAX_LEN];
  int m_y [MAX_LEN];
  int m_len;
  int m_mode;            // 0 waiting for first key, 1 moving, 2 dead
  int m_cnt;             // unpaused cycles since the last move
  int m_due;             // cycles left until the scheduled move lands
  int m_dx, m_dy;        // direction of the move in flight / last move
  int m_pdx, m_pdy;      // latest accepted key direction
  int m_nx, m_ny;
  bit m_kill, m_eat;
  bit e_step, e_ate, e_died;
  bit m_live = 1'b0;
  bit k_ok;
  int k_dx, k_dy;
  int m_nl;
  bit m_wall, m_self;

  task m_reset();
    for (int i = 0; i < MAX_LEN; i++) begin
      m_x[i] = 0;
      m_y[i] = 0;
    end
    m_x[0] = 16; m_y[0] = 12;
    m_x[1] = 15; m_y[1] = 12;
    m_x[2] = 14; m_y[2] = 12;
    m_len = 3; m_mode = 0; m_cnt = 0; m_due = 0;
    m_dx = 1; m_dy = 0; m_pdx = 1; m_pdy = 0;
    e_step = 0; e_ate = 0; e_died = 0;
  endtask

  task decode(input logic [7:0] c, output bit ok, output int dx, output int dy);
    ok = 1; dx = 0; dy = 0;
    case (c)
      K_W:     dy = -1;
      K_A:     dx = -1;
      K_S:     dy = 1;
      K_D:     dx = 1;
      default: ok = 0;
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reset();
    end else begin
      e_step = 0; e_ate = 0; e_died = 0;
      if (bus.init) begin
        m_reset();
      end else if (m_mode != 2) begin
        if (m_due == 2) begin
          m_dx = m_pdx; m_dy = m_pdy;
          m_nx = m_x[0] + m_dx;
          m_ny = m_y[0] + m_dy;
          m_wall = (m_nx < 0) || (m_nx > 31) || (m_ny < 0) || (m_ny > 23);
          m_eat  = !m_wall && (m_nx == int'(bus.food_x)) && (m_ny == int'(bus.food_y));
          m_self = 0;
          for (int i = 0; i < (m_eat ? m_len : m_len - 1); i++)
            if (m_x[i] == m_nx && m_y[i] == m_ny) m_self = 1;
          m_kill = m_wall || m_self;
          m_due = 1;
        end else if (m_due == 1) begin
          if (m_kill) begin
            e_died = 1;
            m_mode = 2;
          end else begin
            e_step = 1;
            m_nl = m_len;
            if (m_eat) begin
              e_ate = 1;
              if (m_len < MAX_LEN) m_nl = m_len + 1;
            end
            for (int i = m_nl - 1; i > 0; i--) begin
              m_x[i] = m_x[i-1];
              m_y[i] = m_y[i-1];
            end
            m_x[0] = m_nx; m_y[0] = m_ny;
            m_len = m_nl;
          end
          m_due = 0;
        end else if (m_mode == 1 && !bus.pause) begin
          m_cnt++;
          if (m_cnt == TICK_DIV) begin
            m_cnt = 0;
            m_due = 2;
          end
        end
        if (bus.key_valid && m_mode != 2) begin
          decode(bus.key_code, k_ok, k_dx, k_dy);
          if (k_ok && !(k_dx == -m_dx && k_dy == -m_dy)) begin
            m_pdx = k_dx; m_pdy = k_dy;
            if (m_mode == 0) m_mode = 1;
          end
        end
      end
    end
  end

  function automatic int m_qhit();
    for (int i = 0; i < m_len; i++)
      if (m_x[i] == int'(bus.qry_x) && m_y[i] == int'(bus.qry_y)) return 1;
    return 0;
  endfunction

  always @(negedge clk) begin
    if (m_live) begin
      chk("cyc_head_x", int'(bus.head_x), m_x[0]);
      chk("cyc_head_y", int'(bus.head_y), m_y[0]);
      chk("cyc_length", int'(bus.length), m_len);
      chk("cyc_step",   int'(bus.step),   int'(e_step));
      chk("cyc_ate",    int'(bus.ate),    int'(e_ate));
      chk("cyc_died",   int'(bus.died),   int'(e_died));
      chk("cyc_qry_hit", int'(bus.qry_hit), m_qhit());
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic press(input logic [7:0] code);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    cyc(1);
    bus.key_valid = 1'b0;
    $display("key 0x%02h -> head (%0d,%0d) len %0d", code, bus.head_x, bus.head_y, bus.length);
  endtask

  task automatic pulse_init();
    bus.init = 1'b1;
    cyc(1);
    bus.init = 1'b0;
    $display("init -> head (%0d,%0d) len %0d", bus.head_x, bus.head_y, bus.length);
  endtask

  task automatic wait_move();
    bit got;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (bus.step || bus.died) begin
        got = 1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL move_timeout: no step/died within 40 cycles (t=%0t)", $time);
    end else begin
      $display("move step=%0d ate=%0d died=%0d head (%0d,%0d) len %0d",
               bus.step, bus.ate, bus.died, bus.head_x, bus.head_y, bus.length);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    bus.init = 0; bus.pause = 0; bus.key_valid = 0; bus.key_code = 8'h00;
    bus.food_x = 5'd30; bus.food_y = 5'd20;
    bus.qry_x = 5'd15; bus.qry_y = 5'd12;
    m_reset();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_head_x", int'(bus.head_x), 16);
    chk("rst_head_y", int'(bus.head_y), 12);
    chk("rst_length", int'(bus.length), 3);
    chk("rst_step",   int'(bus.step), 0);
    chk("rst_died",   int'(bus.died), 0);
    chk("rst_qry_hit", int'(bus.qry_hit), 1);
    rst_n = 1'b1;
    m_live = 1'b1;

    // First move after reset: step lands 6 cycles after the key.
    bus.qry_x = 5'd14;
    press(K_D);
    cyc(5);
    chk("first_no_step_yet", int'(bus.step), 0);
    chk("first_head_x_before", int'(bus.head_x), 16);
    cyc(1);
    chk("first_step", int'(bus.step), 1);
    chk("first_head_x", int'(bus.head_x), 17);
    chk("first_head_y", int'(bus.head_y), 12);
    chk("first_length", int'(bus.length), 3);
    chk("first_qry_old_tail", int'(bus.qry_hit), 0);

    // Reverse key ignored, later legal key wins.
    pulse_init();
    press(K_D);
    press(K_A);
    press(K_W);
    wait_move();
    chk("turn_head_x", int'(bus.head_x), 16);
    chk("turn_head_y", int'(bus.head_y), 11);

    // Drive to the right wall at row 5 and die there.
    repeat (6) wait_move();
    chk("walk_head_y", int'(bus.head_y), 5);
    press(K_D);
    repeat (15) wait_move();
    chk("wall_edge_x", int'(bus.head_x), 31);
    wait_move();
    chk("wall_died", int'(bus.died), 1);
    chk("wall_no_step", int'(bus.step), 0);
    chk("wall_head_x", int'(bus.head_x), 31);
    chk("wall_head_y", int'(bus.head_y), 5);
    pulses = 0;
    for (int i = 0; i < 24; i++) begin
      bus.key_valid = 1'b1;
      bus.key_code  = (i % 2 == 0) ? K_W : K_A;
      bus.pause     = (i % 3 == 0);
      cyc(1);
      if (bus.step || bus.died || bus.ate) pulses++;
    end
    bus.key_valid = 1'b0;
    bus.pause = 1'b0;
    chk("dead_no_pulses", pulses, 0);
    chk("dead_head_x", int'(bus.head_x), 31);
    chk("dead_head_y", int'(bus.head_y), 5);

    // Eat: old tail kept, length grows.
    pulse_init();
    bus.food_x = 5'd17; bus.food_y = 5'd12;
    bus.qry_x = 5'd14; bus.qry_y = 5'd12;
    press(K_D);
    wait_move();
    chk("eat_ate", int'(bus.ate), 1);
    chk("eat_step", int'(bus.step), 1);
    chk("eat_length", int'(bus.length), 4);
    chk("eat_tail_kept", int'(bus.qry_hit), 1);
    bus.food_x = 5'd30; bus.food_y = 5'd20;

    // Square loop onto the vacating tail cell is safe.
    press(K_S);
    wait_move();
    press(K_A);
    wait_move();
    press(K_W);
    wait_move();
    chk("loop_alive", int'(bus.died), 0);
    chk("loop_head_x", int'(bus.head_x), 16);
    chk("loop_head_y", int'(bus.head_y), 12);
    chk("loop_length", int'(bus.length), 4);

    // Same move with food on the tail cell: the tail stays, so it is a collision.
    bus.food_x = 5'd17; bus.food_y = 5'd12;
    press(K_D);
    wait_move();
    chk("tailfood_died", int'(bus.died), 1);
    chk("tailfood_no_ate", int'(bus.ate), 0);
    chk("tailfood_length", int'(bus.length), 4);
    chk("tailfood_head_x", int'(bus.head_x), 16);
    bus.food_x = 5'd30; bus.food_y = 5'd20;

    // Pause mid-count, then init while CALC is in flight.
    pulse_init();
    press(K_D);
    cyc(2);
    bus.pause = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (bus.step) pulses++;
    end
    bus.pause = 1'b0;
    chk("pause_no_step", pulses, 0);
    cyc(2);
    bus.init = 1'b1;
    cyc(1);
    bus.init = 1'b0;
    chk("abort_head_x", int'(bus.head_x), 16);
    chk("abort_head_y", int'(bus.head_y), 12);
    chk("abort_length", int'(bus.length), 3);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (bus.step || bus.died || bus.ate) pulses++;
    end
    chk("abort_no_pulses", pulses, 0);

    // Eat along row 12 until length saturates; the last meal drops the tail.
    pulse_init();
    bus.food_x = 5'd17; bus.food_y = 5'd12;
    press(K_D);
    for (int i = 0; i < 14; i++) begin
      wait_move();
      bus.food_x = 5'(18 + i);
    end
    chk("sat_ate", int'(bus.ate), 1);
    chk("sat_length", int'(bus.length), 16);
    chk("sat_head_x", int'(bus.head_x), 30);
    bus.food_x = 5'd0; bus.food_y = 5'd0;
    bus.qry_x = 5'd14; bus.qry_y = 5'd12;
    #1;
    chk("sat_tail_dropped", int'(bus.qry_hit), 0);
    bus.qry_x = 5'd15;
    #1;
    chk("sat_new_tail", int'(bus.qry_hit), 1);
    cyc(2);

    m_live = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
